// File: rtl/packed_field_rmw_if.sv
// Request/response bundle for packed_field_rmw.
// Master is the register-map front end; slave is the storage block.
interface packed_field_rmw_if #(
  parameter int FIELD_W    = 8,
  parameter int NUM_FIELDS = 2,
  parameter int DEPTH      = 4,
  parameter int SRC_W      = FIELD_W*NUM_FIELDS+1
);
  localparam int WORD_W = FIELD_W*NUM_FIELDS;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(NUM_FIELDS);
  localparam int LW = $clog2(WORD_W);
  localparam int NW = LW+1;
  localparam int SW = $clog2(SRC_W)+1;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [AW-1:0]     req_addr;
  logic [1:0]        req_mode;
  logic [FW-1:0]     req_field;
  logic [LW-1:0]     req_lsb;
  logic [NW-1:0]     req_len;
  logic [SW-1:0]     req_src_len;
  logic [SRC_W-1:0]  req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_data;
  logic [WORD_W-1:0] rsp_vmask;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_mode,
    output req_field, req_lsb, req_len, req_src_len,
    output req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_vmask,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_mode,
    input  req_field, req_lsb, req_len, req_src_len,
    input  req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_vmask,
    output rsp_err
  );
endinterface

// File: rtl/packed_field_rmw.sv
// Packed-word store with field/slice read-modify-write
// and a per-bit written mask standing in for X.
module packed_field_rmw #(
  parameter int FIELD_W    = 8,
  parameter int NUM_FIELDS = 2,
  parameter int DEPTH      = 4,
  parameter int SRC_W      = FIELD_W*NUM_FIELDS+1
) (
  input logic               clk,
  input logic               rst_n,
  packed_field_rmw_if.slave bus
);
  localparam int WORD_W = FIELD_W*NUM_FIELDS;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(NUM_FIELDS);
  localparam int LW = $clog2(WORD_W);
  localparam int NW = LW+1;
  localparam int SW = $clog2(SRC_W)+1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nx;

  logic              r_write;
  logic [AW-1:0]     r_addr;
  logic [1:0]        r_mode;
  logic [FW-1:0]     r_field;
  logic [LW-1:0]     r_lsb;
  logic [NW-1:0]     r_len;
  logic [SW-1:0]     r_src_len;
  logic [SRC_W-1:0]  r_data;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] vmk [DEPTH];

  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [WORD_W-1:0] rsp_data_q;
  logic [WORD_W-1:0] rsp_vmask_q;

  logic addr_bad;
  logic field_bad;

  // Range checks only exist when the index width can overshoot.
  if ((1 << AW) == DEPTH) begin : g_addr_full
    assign addr_bad = 1'b0;
  end else begin : g_addr_part
    assign addr_bad = (r_addr >= AW'(DEPTH));
  end

  if ((1 << FW) == NUM_FIELDS) begin : g_fld_full
    assign field_bad = 1'b0;
  end else begin : g_fld_part
    assign field_bad = (r_field >= FW'(NUM_FIELDS));
  end

  logic [31:0]       sl;
  logic [SRC_W:0]    sone;
  logic [SRC_W:0]    smask;
  logic [SRC_W-1:0]  s_eff;
  logic [31:0]       base;
  logic [31:0]       tlen;
  logic [31:0]       span;
  logic [WORD_W:0]   tone;
  logic [WORD_W:0]   tmask;
  logic [WORD_W-1:0] lenmask;
  logic [WORD_W-1:0] region;
  logic [WORD_W-1:0] wval;
  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] cur_vm;
  logic [WORD_W-1:0] new_word;
  logic [WORD_W-1:0] new_vm;
  logic              err;
  logic              do_write;

  always_comb begin
    sl = 32'(r_src_len);
    if (sl > 32'(SRC_W)) sl = 32'(SRC_W);
    sone  = (SRC_W+1)'(1) << sl;
    smask = sone - (SRC_W+1)'(1);
    s_eff = r_data & smask[SRC_W-1:0];

    base = '0;
    tlen = 32'(WORD_W);
    unique case (r_mode)
      2'b00: begin
        base = '0;
        tlen = 32'(WORD_W);
      end
      2'b01: begin
        base = 32'(r_field) * 32'(FIELD_W);
        tlen = 32'(FIELD_W);
      end
      2'b10: begin
        base = 32'(r_lsb);
        tlen = 32'(r_len);
      end
      2'b11: begin
        base = 32'(r_field) * 32'(FIELD_W)
             + 32'(r_lsb);
        tlen = 32'(r_len);
      end
    endcase
    span = 32'(r_lsb) + 32'(r_len);

    tone    = (WORD_W+1)'(1) << tlen;
    tmask   = tone - (WORD_W+1)'(1);
    lenmask = tmask[WORD_W-1:0];
    region  = lenmask << base;
    wval    = (WORD_W'(s_eff) & lenmask) << base;

    cur_word = addr_bad ? '0 : mem[r_addr];
    cur_vm   = addr_bad ? '0 : vmk[r_addr];
    new_word = (cur_word & ~region) | wval;
    new_vm   = cur_vm | region;

    err = addr_bad
        | (r_write & r_mode[0] & field_bad)
        | (r_write & r_mode[1] & (r_len == '0))
        | ((r_mode == 2'b10) && (span > 32'(WORD_W)))
        | ((r_mode == 2'b11) && (span > 32'(FIELD_W)));
    do_write = r_write & ~err;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.req_valid) state_nx = EXEC;
      EXEC: state_nx = RESP;
      RESP: if (rsp_valid_q && bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_mode      <= '0;
      r_field     <= '0;
      r_lsb       <= '0;
      r_len       <= '0;
      r_src_len   <= '0;
      r_data      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_vmask_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
        vmk[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.req_valid) begin
        r_write   <= bus.req_write;
        r_addr    <= bus.req_addr;
        r_mode    <= bus.req_mode;
        r_field   <= bus.req_field;
        r_lsb     <= bus.req_lsb;
        r_len     <= bus.req_len;
        r_src_len <= bus.req_src_len;
        r_data    <= bus.req_data;
      end
      if (state == EXEC) begin
        if (do_write) begin
          mem[r_addr] <= new_word;
          vmk[r_addr] <= new_vm;
        end
        rsp_data_q  <= do_write ? new_word : cur_word;
        rsp_vmask_q <= do_write ? new_vm : cur_vm;
        rsp_err_q   <= err;
      end
      rsp_valid_q <= (state == RESP)
                  && !(rsp_valid_q && bus.rsp_ready);
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_vmask = rsp_vmask_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_packed_field_rmw.sv
// Directed bench for packed_field_rmw with an
// expected-response queue and immediate assertions.
module tb_packed_field_rmw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  packed_field_rmw_if bus ();

  packed_field_rmw dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] data;
    logic [15:0] vmask;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_mode    = '0;
    bus.req_field   = '0;
    bus.req_lsb     = '0;
    bus.req_len     = '0;
    bus.req_src_len = '0;
    bus.req_data    = '0;
    bus.rsp_ready   = 1'b1;
  endtask

  task automatic req(input string tag,
                     input logic w,
                     input logic [1:0] addr,
                     input logic [1:0] mode,
                     input logic fld,
                     input logic [3:0] lsb,
                     input logic [4:0] len,
                     input logic [5:0] sl,
                     input logic [16:0] data,
                     input logic [15:0] ed,
                     input logic [15:0] ev,
                     input logic ee,
                     input int hold);
    exp_t e;
    int n;
    e.data = ed;
    e.vmask = ev;
    e.err = ee;
    sb.push_back(e);
    @(negedge clk);
    bus.req_write   = w;
    bus.req_addr    = addr;
    bus.req_mode    = mode;
    bus.req_field   = fld;
    bus.req_lsb     = lsb;
    bus.req_len     = len;
    bus.req_src_len = sl;
    bus.req_data    = data;
    bus.req_valid   = 1'b1;
    bus.rsp_ready   = (hold == 0);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/accept"}, 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "/latency"}, n, 2);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "/hold_valid"}, 32'(bus.rsp_valid), 1);
      chk({tag, "/hold_ready"}, 32'(bus.req_ready), 0);
      chk({tag, "/hold_data"}, 32'(bus.rsp_data), 32'(ed));
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, "/queue"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "/data"}, 32'(bus.rsp_data), 32'(e.data));
      chk({tag, "/vmask"}, 32'(bus.rsp_vmask), 32'(e.vmask));
      chk({tag, "/err"}, 32'(bus.rsp_err), 32'(e.err));
    end
    @(posedge clk);
    #1;
    chk({tag, "/drop"}, 32'(bus.rsp_valid), 0);
    chk({tag, "/idle"}, 32'(bus.req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst/req_ready", 32'(bus.req_ready), 1);
    chk("rst/rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst/rsp_data", 32'(bus.rsp_data), 0);
    chk("rst/rsp_vmask", 32'(bus.rsp_vmask), 0);
    chk("rst/rsp_err", 32'(bus.rsp_err), 0);

    req("rd_unwritten", 0, 3, 0, 0, 0, 0, 0, 17'h0,
        16'h0000, 16'h0000, 0, 0);
    req("a0_f1", 1, 0, 2'b01, 1, 0, 0, 8, 17'hFF,
        16'hFF00, 16'hFF00, 0, 0);
    req("a0_f0", 1, 0, 2'b01, 0, 0, 0, 8, 17'h0,
        16'hFF00, 16'hFFFF, 0, 0);
    req("a1_trunc", 1, 1, 2'b01, 1, 0, 0, 9, 17'h1FF,
        16'hFF00, 16'hFF00, 0, 0);
    req("a1_zext", 1, 1, 2'b01, 1, 0, 0, 7, 17'h1FF,
        16'h7F00, 16'hFF00, 0, 0);
    req("a2_wslice", 1, 2, 2'b10, 0, 4, 8, 7, 17'h1FFFF,
        16'h07F0, 16'h0FF0, 0, 0);
    req("a2_fslice", 1, 2, 2'b11, 0, 0, 4, 4, 17'h0,
        16'h07F0, 16'h0FFF, 0, 0);
    req("a3_full17", 1, 3, 2'b00, 0, 0, 0, 17, 17'h1FFFF,
        16'hFFFF, 16'hFFFF, 0, 0);
    req("a3_full15", 1, 3, 2'b00, 0, 0, 0, 15, 17'h1FFFF,
        16'h7FFF, 16'hFFFF, 0, 0);
    req("a3_hold", 0, 3, 0, 0, 0, 0, 0, 17'h0,
        16'h7FFF, 16'hFFFF, 0, 5);

    req("err_wslice", 1, 0, 2'b10, 0, 12, 8, 8, 17'hFF,
        16'hFF00, 16'hFFFF, 1, 0);
    req("err_fslice", 1, 2, 2'b11, 0, 6, 4, 4, 17'hF,
        16'h07F0, 16'h0FFF, 1, 0);
    req("err_len0", 1, 1, 2'b10, 0, 0, 0, 8, 17'hFF,
        16'h7F00, 16'hFF00, 1, 0);
    req("a0_after_err", 0, 0, 0, 0, 0, 0, 0, 17'h0,
        16'hFF00, 16'hFFFF, 0, 0);
    req("clamp_src", 1, 1, 2'b00, 0, 0, 0, 63, 17'h1FFFF,
        16'hFFFF, 16'hFFFF, 0, 0);
    req("fslice_top", 1, 2, 2'b11, 1, 4, 4, 3, 17'h1F,
        16'h77F0, 16'hFFFF, 0, 0);

    @(negedge clk);
    bus.req_write   = 1'b1;
    bus.req_addr    = 2'd0;
    bus.req_mode    = 2'b00;
    bus.req_src_len = 6'd16;
    bus.req_data    = 17'h1234;
    bus.req_valid   = 1'b1;
    bus.rsp_ready   = 1'b1;
    chk("abort/accept", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort/rsp_valid", 32'(bus.rsp_valid), 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_in();
    req("abort_rd_a0", 0, 0, 0, 0, 0, 0, 0, 17'h0,
        16'h0000, 16'h0000, 0, 0);
    req("abort_rd_a3", 0, 3, 0, 0, 0, 0, 0, 17'h0,
        16'h0000, 16'h0000, 0, 0);

    chk("queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
